// File: rtl/rgb_frame_fetch_pkg.sv
// Shared types and constants for the RGB frame fetch client.
package rgb_frame_fetch_pkg;

    typedef enum logic [1:0] {
        S_RGBF_IDLE,
        S_RGBF_FETCH,
        S_RGBF_DRAIN
    } RGBF_state_type;

    localparam logic [17:0] RGB_SEGMENT_BASE = 18'd146944;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_pixel_t;

    // Word phase within a three-word group: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        return (ph == 2'd2) ? 2'd0 : ph + 2'd1;
    endfunction

endpackage

// File: rtl/rgb_frame_fetch_pixel_fifo.sv
// Small synchronous 24-bit pixel FIFO; simultaneous push and pop are always honoured.
module pixel_fifo
    import rgb_frame_fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [23:0]   data_i,
    input  logic          pop_i,
    output logic [23:0]   data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [23:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    // Head is forced to zero when empty so the outputs read as zero out of reset.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rgb_frame_fetch.sv
// Streams a packed 24-bit RGB frame out of SRAM as {R,G,B} pixels in raster order.
module rgb_frame_fetch
    import rgb_frame_fetch_pkg::*;
#(
    parameter logic [17:0] RGB_BASE   = RGB_SEGMENT_BASE,
    parameter int          IMG_W      = 320,
    parameter int          IMG_H      = 240,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        start,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_R,
    output logic [7:0]  pix_G,
    output logic [7:0]  pix_B,
    output logic        line_end,
    output logic        frame_done,
    output logic        busy
);

    localparam int FRAME_WORDS = 3 * IMG_W * IMG_H / 2;
    localparam logic [17:0] LAST_ADDR = 18'(int'(RGB_BASE) + FRAME_WORDS - 1);
    localparam int RW = $clog2(FIFO_DEPTH) + 1;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    RGBF_state_type state_q;
    logic [17:0]    addr_q;
    logic           issue_q;
    logic [1:0]     phase_q;
    logic           busy_q;
    logic           frame_done_q;
    logic           line_end_q;

    logic           v1_q, v2_q;
    logic [1:0]     ph1_q, ph2_q;
    logic [7:0]     r_lat_q, g_lat_q;

    logic [RW-1:0]  reserved_q, reserved_d;
    logic [XW-1:0]  x_q;
    logic [YW-1:0]  y_q;

    logic           pop;
    logic           mid_group;
    logic           last_word;
    logic           credit_ok;
    logic           group_begin;
    logic           last_pix;
    logic           drain_done;
    logic           unpack_push;
    logic           push_en;
    logic [23:0]    push_data;
    logic [23:0]    head_data;
    rgb_pixel_t     head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [RW-1:0]  fifo_count;

    assign pop       = ~fifo_empty & pix_ready;
    assign mid_group = issue_q & (phase_q != 2'd2);
    assign last_word = (addr_q == LAST_ADDR);
    assign credit_ok = (reserved_q <= RW'(FIFO_DEPTH - 2));
    assign last_pix  = (x_q == X_LAST) & (y_q == Y_LAST);
    assign drain_done = pop & last_pix & (fifo_count == RW'(1))
                      & ~issue_q & ~v1_q & ~v2_q;

    assign group_begin = ((state_q == S_RGBF_IDLE) & start)
                       | ((state_q == S_RGBF_FETCH) & ~mid_group & ~last_word & credit_ok);

    // Credits count FIFO occupancy plus pixels still travelling back from SRAM.
    always_comb begin
        reserved_d = reserved_q;
        if (group_begin) begin
            reserved_d = reserved_d + RW'(2);
        end
        if (pop) begin
            reserved_d = reserved_d - RW'(1);
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_RGBF_IDLE;
            addr_q       <= RGB_BASE;
            issue_q      <= 1'b0;
            phase_q      <= 2'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_RGBF_IDLE: begin
                    issue_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RGBF_FETCH;
                        addr_q  <= RGB_BASE;
                        issue_q <= 1'b1;
                        phase_q <= 2'd0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RGBF_FETCH: begin
                    if (mid_group) begin
                        addr_q  <= addr_q + 18'd1;
                        phase_q <= next_phase(phase_q);
                        issue_q <= 1'b1;
                    end else if (last_word) begin
                        state_q <= S_RGBF_DRAIN;
                        issue_q <= 1'b0;
                    end else if (credit_ok) begin
                        addr_q  <= addr_q + 18'd1;
                        phase_q <= 2'd0;
                        issue_q <= 1'b1;
                    end else begin
                        issue_q <= 1'b0;
                    end
                end
                S_RGBF_DRAIN: begin
                    issue_q <= 1'b0;
                    if (drain_done) begin
                        state_q      <= S_RGBF_IDLE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_RGBF_IDLE;
                    issue_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage tag pipe lines each returned word up with its group phase.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            ph1_q      <= 2'd0;
            ph2_q      <= 2'd0;
            r_lat_q    <= 8'd0;
            g_lat_q    <= 8'd0;
            reserved_q <= '0;
        end else begin
            v1_q       <= issue_q;
            ph1_q      <= phase_q;
            v2_q       <= v1_q;
            ph2_q      <= ph1_q;
            reserved_q <= reserved_d;
            if (v2_q) begin
                case (ph2_q)
                    2'd0: begin
                        r_lat_q <= SRAM_read_data[15:8];
                        g_lat_q <= SRAM_read_data[7:0];
                    end
                    2'd1: begin
                        r_lat_q <= SRAM_read_data[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign unpack_push = v2_q & (ph2_q != 2'd0);
    assign push_en     = unpack_push & (~fifo_full | pop);
    assign push_data   = (ph2_q == 2'd1) ? {r_lat_q, g_lat_q, SRAM_read_data[15:8]}
                                         : {r_lat_q, SRAM_read_data};

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLOCK_50_I),
        .rst_ni  (resetn),
        .push_i  (push_en),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            x_q        <= '0;
            y_q        <= '0;
            line_end_q <= 1'b0;
        end else begin
            line_end_q <= pop & (x_q == X_LAST);
            if (pop) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
        end
    end

    assign head         = head_data;
    assign pix_R        = head.r;
    assign pix_G        = head.g;
    assign pix_B        = head.b;
    assign pix_valid    = ~fifo_empty;
    assign SRAM_address = addr_q;
    assign SRAM_we_n    = 1'b1;
    assign line_end     = line_end_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_rgb_frame_fetch.sv
// Bench for rgb_frame_fetch: reduced frame placed at the top of SRAM, randomized readiness.
module tb_rgb_frame_fetch;

    localparam int          W      = 32;
    localparam int          H      = 8;
    localparam int          DEPTH  = 8;
    localparam int          NPIX   = W * H;
    localparam logic [17:0] BASE   = 18'd261760;
    localparam int          LAST   = 262143;
    localparam int          BUDGET = 4000;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_R, pix_G, pix_B;
    logic        line_end;
    logic        frame_done;
    logic        busy;

    int errors;
    int checks;
    int pop_idx;
    int line_cnt;
    int done_cnt;
    int max_count;
    int max_addr;
    int we_bad;
    logic mon_en;
    logic [17:0] a_d1;

    rgb_frame_fetch #(
        .RGB_BASE   (BASE),
        .IMG_W      (W),
        .IMG_H      (H),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLOCK_50_I     (clk),
        .resetn         (resetn),
        .start          (start),
        .SRAM_address   (SRAM_address),
        .SRAM_we_n      (SRAM_we_n),
        .SRAM_read_data (SRAM_read_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_R          (pix_R),
        .pix_G          (pix_G),
        .pix_B          (pix_B),
        .line_end       (line_end),
        .frame_done     (frame_done),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Segment word i holds i[15:0]; data appears two cycles after its address.
    function automatic logic [15:0] word_at(input logic [17:0] a);
        int r;
        r = int'(a) - int'(BASE);
        return r[15:0];
    endfunction

    always @(posedge clk) begin
        a_d1           <= SRAM_address;
        SRAM_read_data <= word_at(a_d1);
    end

    // Expected pixel p straight from the packing rule applied to segment word values.
    function automatic logic [23:0] golden(input int p);
        int t;
        logic [15:0] w0, w1, w2;
        t  = 3 * (p / 2);
        w0 = t[15:0];
        t  = t + 1;
        w1 = t[15:0];
        t  = t + 1;
        w2 = t[15:0];
        if (p % 2 == 0) return {w0, w1[15:8]};
        else            return {w1[7:0], w2};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (line_end) begin
                line_cnt++;
                check("line_end_pos", 32'((pop_idx - 1) % W), 32'(W - 1));
            end
            if (frame_done) begin
                done_cnt++;
                check("done_pixels", 32'(pop_idx), 32'(NPIX));
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
            if (pix_valid && pix_ready) begin
                check($sformatf("pixel%0d", pop_idx), {8'd0, pix_R, pix_G, pix_B},
                      {8'd0, golden(pop_idx)});
                pop_idx++;
            end
            if (int'(dut.u_fifo.count_o) > max_count) max_count = int'(dut.u_fifo.count_o);
            if (busy && int'(SRAM_address) > max_addr) max_addr = int'(SRAM_address);
            if (SRAM_we_n !== 1'b1) we_bad++;
        end
    end

    // mode: 0 ready high, 1 ready low for 50 cycles, 2 random ready, 3 ready high with start spam.
    task automatic run_frame(input int mode, input int abort_at, input string name);
        int n;
        logic [17:0] addr40;
        pop_idx   = 0;
        line_cnt  = 0;
        done_cnt  = 0;
        max_count = 0;
        max_addr  = 0;
        addr40    = '0;
        pix_ready = (mode == 0 || mode == 3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        while (done_cnt == 0 && n <= BUDGET && !(abort_at > 0 && pop_idx >= abort_at)) begin
            case (mode)
                1:       pix_ready = (n > 50);
                2:       pix_ready = 1'($urandom_range(0, 1));
                3:       start = (n % 10 == 0) && busy;
                default: ;
            endcase
            @(negedge clk);
            #1;
            if (mode == 0) begin
                if (n <= 3) check($sformatf("addr_cycle%0d", n), 32'(SRAM_address), 32'(BASE) + 32'(n - 1));
                if (n == 4) check("valid_cycle4", {31'd0, pix_valid}, 32'd0);
                if (n == 5) begin
                    check("valid_cycle5", {31'd0, pix_valid}, 32'd1);
                    check("pix0_value", {8'd0, pix_R, pix_G, pix_B}, 32'h000000);
                end
                if (n == 6) check("pix1_value", {8'd0, pix_R, pix_G, pix_B}, 32'h010002);
            end
            if (mode == 1) begin
                if (n == 40) addr40 = SRAM_address;
                if (n == 50) begin
                    check("stall_buffered", 32'(dut.u_fifo.count_o), 32'(DEPTH));
                    check("stall_addr_frozen", 32'(SRAM_address), 32'(addr40));
                    check("stall_addr", 32'(SRAM_address), 32'(BASE) + 32'd11);
                    check("stall_no_pops", 32'(pop_idx), 32'd0);
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        if (abort_at > 0) begin
            check("abort_reached", {31'd0, pop_idx >= abort_at}, 32'd1);
            $display("%s: stopped after %0d pixels", name, pop_idx);
        end else begin
            check("frame_done_seen", 32'(done_cnt), 32'd1);
            repeat (20) @(posedge clk);
            #1;
            check("frame_done_once", 32'(done_cnt), 32'd1);
            check("pixel_total", 32'(pop_idx), 32'(NPIX));
            check("line_end_total", 32'(line_cnt), 32'(H));
            check("last_addr", 32'(max_addr), 32'(LAST));
            check("fifo_bound", {31'd0, max_count <= DEPTH}, 32'd1);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_valid", {31'd0, pix_valid}, 32'd0);
            $display("%s: %0d pixels, %0d line_end, %0d frame_done, max fifo %0d",
                     name, pop_idx, line_cnt, done_cnt, max_count);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 32'(SRAM_address), 32'(BASE));
        check({tag, "_we_n"}, {31'd0, SRAM_we_n}, 32'd1);
        check({tag, "_valid"}, {31'd0, pix_valid}, 32'd0);
        check({tag, "_rgb"}, {8'd0, pix_R, pix_G, pix_B}, 32'd0);
        check({tag, "_line_end"}, {31'd0, line_end}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        we_bad    = 0;
        pop_idx   = 0;
        line_cnt  = 0;
        done_cnt  = 0;
        max_count = 0;
        max_addr  = 0;
        mon_en    = 1'b0;
        resetn    = 1'b0;
        start     = 1'b0;
        pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 mon_en = 1'b1;

        run_frame(0, 0, "unthrottled");
        run_frame(1, 0, "backpressure");
        run_frame(2, 0, "random_ready");
        run_frame(0, 100, "pre_reset");

        #5 resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;
        run_frame(0, 0, "after_reset");
        run_frame(3, 0, "start_spam");

        check("we_n_high", 32'(we_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_frame_fetch.md
# rgb_frame_fetch

Read-only SRAM client that streams the RGB frame (320×240, 24-bit pixels) out of the RGB segment produced by the colour-space conversion stage. It fetches the packed 16-bit words in three-word groups, unpacks each group into two `{R,G,B}` pixels, and buffers them in a small FIFO. Pixels are delivered in raster order over a valid/ready handshake to the display path.

## Interface
Parameters:
- `RGB_BASE`, 146944: SRAM word address of pixel 0 (`{R0,G0}`).
- `IMG_W`, 320: pixels per line. Must be even.
- `IMG_H`, 240: lines per frame.
- `FIFO_DEPTH`, 8: pixel FIFO entries. Power of two, ≥4.

Ports:
- `CLOCK_50_I`, in, 1: 50 MHz clock. The only clock.
- `resetn`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle pulse that begins a frame fetch. Ignored unless in IDLE.
- `SRAM_address`, out, 18: registered read address.
- `SRAM_we_n`, out, 1: constant 1; this block never writes.
- `SRAM_read_data`, in, 16: word for the address presented 2 cycles earlier.
- `pix_valid`, out, 1: FIFO non-empty.
- `pix_ready`, in, 1: consumer accepts a pixel when `pix_valid & pix_ready`.
- `pix_R`, `pix_G`, `pix_B`, out, 8 each: head-of-FIFO pixel.
- `line_end`, out, 1: 1-cycle pulse in the cycle after the last pixel of a line is popped.
- `frame_done`, out, 1: 1-cycle pulse in the cycle after the final frame pixel is popped.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- Packing, per pixel pair k: word at `RGB_BASE+3k` is `{R2k,G2k}`, `+3k+1` is `{B2k,R2k+1}`, `+3k+2` is `{G2k+1,B2k+1}`. High byte comes first.
- The frame occupies `3·IMG_W·IMG_H/2` words. With the defaults this is 115200 words, and the last address is 262143. The address never wraps.
- FSM:
  - IDLE → FETCH on `start`.
  - FETCH issues one address per cycle in groups of three. It may begin a group only when `reserved ≤ FIFO_DEPTH−2`.
  - FETCH → DRAIN after the last word's address is issued.
  - DRAIN → IDLE when no reads are in flight, the FIFO is empty, and the final pixel has been popped. `frame_done` pulses on this transition.
- Credit counter `reserved` tracks FIFO occupancy plus pixels in flight:
  - +2 when a group begins.
  - −1 on each pop.
  - Both events in the same cycle give a net +1.
  - It never exceeds `FIFO_DEPTH`, so the FIFO can never overflow.
- Return path: a 2-deep valid shift register tags returned words with phase 0/1/2.
  - Phase 0: latch R,G.
  - Phase 1: push `{R,G,B}` of the even pixel, then latch R of the odd pixel.
  - Phase 2: push the odd pixel.
- A FIFO push and pop in the same cycle are both honoured, including push when full-1 with a pop, and pop when 1 with a push.
- Counters x (0..IMG_W−1) and y (0..IMG_H−1) advance on pops only and drive `line_end` and `frame_done`.
- `start` arriving while `busy` has no effect.

## Timing
- Reset values:
  - `SRAM_address = RGB_BASE`, `SRAM_we_n = 1`.
  - `pix_valid = 0`, `pix_R/G/B = 0`.
  - `line_end = 0`, `frame_done = 0`, `busy = 0`.
  - FSM in IDLE; FIFO, counters and credits cleared.
- Start latency: `start` sampled at edge 0 puts `RGB_BASE` on `SRAM_address` in cycle 1, +1 in cycle 2, +2 in cycle 3.
  - Pixel 0 is pushed at edge 4, so `pix_valid = 1` from cycle 5.
  - Pixel 1 is valid from cycle 6.
- Throughput: 2 pixels per 3 cycles with `pix_ready` held high.
- Backpressure: with `pix_ready = 0`, issue stops once `reserved > FIFO_DEPTH−2`. In-flight words still land in the FIFO, and no data is lost or duplicated.
- `pix_R/G/B` hold steady while `pix_valid & ~pix_ready`.
- Reset mid-frame: asserting `resetn` low returns every output to its reset value immediately. In-flight data is discarded. A new `start` fetches from `RGB_BASE`.

## Structure
- Shared package (alongside the other state typedefs): `RGBF_state_type` {S_RGBF_IDLE, S_RGBF_FETCH, S_RGBF_DRAIN} and the segment constant `RGB_SEGMENT_BASE = 18'd146944`.
- Sub-module `pixel_fifo`: synchronous 24-bit FIFO parameterised by depth, with `full`, `empty` and `count` outputs.
- The FSM, credit counter, unpacker and x/y counters live in the top module.

## Test plan
- Unthrottled frame: preload the SRAM model so word i = i[15:0]; `start`, `pix_ready = 1`.
  - First pixel is `{0x00,0x00,0x00}` at cycle 5; pixel 1 is `{0x01,0x00,0x02}`.
  - 76800 pixels are delivered, `frame_done` fires exactly once, and the last address issued is 262143.
- Backpressure: hold `pix_ready = 0` for 50 cycles after `start`.
  - Exactly 8 pixels are buffered and the address freezes.
  - On release the pixel sequence is unbroken and identical to the unthrottled case.
- Random `pix_ready` (50% duty) over a full frame.
  - Output matches the golden model bit-exact and the FIFO never overflows (assertion).
- Line boundaries: `line_end` pulses 240 times, each one after pixel index 319+320n is popped.
- Mid-frame reset after 1000 pixels.
  - All outputs return to their reset values.
  - A new `start` delivers pixel 0 first.
- `start` pulses every 10 cycles during a frame are ignored; the pixel count stays 76800.
